// File: rtl/rect_pos_ctrl.sv
// Frame-synchronous rectangle bounds controller: stages one command until the
// next vertical-blank rise and optionally bounces the rectangle once per frame.
module rect_pos_ctrl #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned INIT_X   = 0,
    parameter int unsigned INIT_Y   = 0,
    parameter int unsigned INIT_W   = 32,
    parameter int unsigned INIT_H   = 32
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       vblnk_in,
    input  logic       mode,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_x,
    input  logic [9:0] cmd_y,
    input  logic [9:0] cmd_w,
    input  logic [9:0] cmd_h,
    input  logic [3:0] cmd_vx,
    input  logic [3:0] cmd_vy,
    output logic [9:0] hmin,
    output logic [9:0] hmax,
    output logic [9:0] vmin,
    output logic [9:0] vmax,
    output logic       frame_tick,
    output logic       pending
);
    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM = 11'(V_ACTIVE);
    localparam logic [9:0]  X0    = 10'(INIT_X);
    localparam logic [9:0]  Y0    = 10'(INIT_Y);
    localparam logic [9:0]  W0    = 10'(INIT_W);
    localparam logic [9:0]  H0    = 10'(INIT_H);
    localparam logic [9:0]  XE0   = 10'(INIT_X + INIT_W - 1);
    localparam logic [9:0]  YE0   = 10'(INIT_Y + INIT_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_PENDING, S_UPDATE, S_LOAD} state_t;

    function automatic logic [9:0] size_fix(input logic [9:0] s, input logic [10:0] lim);
        logic [9:0] r;
        if (s == 10'd0)              r = 10'd1;
        else if ({1'b0, s} > lim)    r = lim[9:0];
        else                         r = s;
        return r;
    endfunction

    function automatic logic [9:0] pos_fix(input logic [9:0] p, input logic [9:0] s,
                                           input logic [10:0] lim);
        logic [10:0] sum;
        logic [9:0]  r;
        sum = {1'b0, p} + {1'b0, s};
        if (sum > lim) r = 10'(lim - {1'b0, s});
        else           r = p;
        return r;
    endfunction

    // -(-8) does not fit in 4 bits, so the reflection saturates to +7
    function automatic logic [3:0] neg_sat(input logic [3:0] v);
        logic [3:0] r;
        if (v == 4'b1000) r = 4'd7;
        else              r = ~v + 4'd1;
        return r;
    endfunction

    // Returns {position, velocity} after one bounce step on one axis.
    function automatic logic [13:0] bounce(input logic [9:0] p, input logic [3:0] v,
                                           input logic [9:0] s, input logic [10:0] lim);
        logic signed [11:0] np;
        logic [13:0]        r;
        np = $signed({2'b00, p}) + $signed({{8{v[3]}}, v});
        if (np[11])
            r = {10'd0, neg_sat(v)};
        else if ((np + $signed({2'b00, s})) > $signed({1'b0, lim}))
            r = {10'(lim - {1'b0, s}), neg_sat(v)};
        else
            r = {np[9:0], v};
        return r;
    endfunction

    state_t     state_q, state_d;
    logic       vblnk_q, vb_rise_s, take_s;
    logic       use_cmd_q, use_cmd_d;
    logic [9:0] stg_x_q, stg_y_q, stg_w_q, stg_h_q;
    logic [3:0] stg_vx_q, stg_vy_q;
    logic [9:0] x_q, y_q, w_q, h_q, x_d, y_d, w_d, h_d;
    logic [3:0] vx_q, vy_q, vx_d, vy_d;
    logic [9:0] hmin_q, hmax_q, vmin_q, vmax_q;
    logic       frame_tick_q, cmd_ready_q, pending_q;

    assign vb_rise_s = vblnk_in & ~vblnk_q;

    always_comb begin
        state_d   = state_q;
        use_cmd_d = use_cmd_q;
        take_s    = 1'b0;
        x_d  = x_q;  y_d  = y_q;  w_d = w_q; h_d = h_q;
        vx_d = vx_q; vy_d = vy_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    take_s  = 1'b1;
                    state_d = S_PENDING;
                end else if (vb_rise_s) begin
                    state_d = S_UPDATE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PENDING: begin
                if (vb_rise_s) begin
                    state_d   = S_UPDATE;
                    use_cmd_d = 1'b1;
                end else begin
                    state_d = S_PENDING;
                end
            end
            S_UPDATE: begin
                state_d = S_LOAD;
                if (use_cmd_q) begin
                    w_d  = size_fix(stg_w_q, H_LIM);
                    h_d  = size_fix(stg_h_q, V_LIM);
                    x_d  = pos_fix(stg_x_q, w_d, H_LIM);
                    y_d  = pos_fix(stg_y_q, h_d, V_LIM);
                    vx_d = stg_vx_q;
                    vy_d = stg_vy_q;
                end else if (mode) begin
                    {x_d, vx_d} = bounce(x_q, vx_q, w_q, H_LIM);
                    {y_d, vy_d} = bounce(y_q, vy_q, h_q, V_LIM);
                end else begin
                    x_d = x_q;
                    y_d = y_q;
                end
            end
            S_LOAD: begin
                state_d   = S_IDLE;
                use_cmd_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            vblnk_q   <= 1'b0;
            use_cmd_q <= 1'b0;
            stg_x_q   <= 10'd0; stg_y_q  <= 10'd0;
            stg_w_q   <= 10'd0; stg_h_q  <= 10'd0;
            stg_vx_q  <= 4'd0;  stg_vy_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            vblnk_q   <= vblnk_in;
            use_cmd_q <= use_cmd_d;
            if (take_s) begin
                stg_x_q  <= cmd_x;  stg_y_q  <= cmd_y;
                stg_w_q  <= cmd_w;  stg_h_q  <= cmd_h;
                stg_vx_q <= cmd_vx; stg_vy_q <= cmd_vy;
            end
        end
    end

    // Working geometry is committed at the end of UPDATE, published at the end of LOAD.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= X0; y_q <= Y0; w_q <= W0; h_q <= H0;
            vx_q <= 4'd0; vy_q <= 4'd0;
        end else begin
            x_q <= x_d; y_q <= y_d; w_q <= w_d; h_q <= h_d;
            vx_q <= vx_d; vy_q <= vy_d;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hmin_q       <= X0;  hmax_q <= XE0;
            vmin_q       <= Y0;  vmax_q <= YE0;
            frame_tick_q <= 1'b0;
            cmd_ready_q  <= 1'b1;
            pending_q    <= 1'b0;
        end else begin
            if (state_q == S_LOAD) begin
                hmin_q <= x_q;
                hmax_q <= 10'({1'b0, x_q} + {1'b0, w_q} - 11'd1);
                vmin_q <= y_q;
                vmax_q <= 10'({1'b0, y_q} + {1'b0, h_q} - 11'd1);
            end
            frame_tick_q <= (state_q == S_LOAD);
            cmd_ready_q  <= (state_d == S_IDLE);
            pending_q    <= (state_d == S_PENDING);
        end
    end

    assign hmin       = hmin_q;
    assign hmax       = hmax_q;
    assign vmin       = vmin_q;
    assign vmax       = vmax_q;
    assign frame_tick = frame_tick_q;
    assign cmd_ready  = cmd_ready_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_rect_pos_ctrl.sv
// Self-checking bench for rect_pos_ctrl: directed scenarios plus randomized
// frames checked against an integer-arithmetic reference model.
module tb_rect_pos_ctrl;
    localparam int HA = 800;
    localparam int VA = 600;

    logic       pclk = 1'b0;
    logic       rst_n, vblnk_in, mode, cmd_valid, cmd_ready;
    logic [9:0] cmd_x, cmd_y, cmd_w, cmd_h;
    logic [3:0] cmd_vx, cmd_vy;
    logic [9:0] hmin, hmax, vmin, vmax;
    logic       frame_tick, pending;

    int n_vec = 0;
    int n_err = 0;

    int mx, my, mw, mh, mvx, mvy;
    bit m_staged;
    int sx, sy, sw, sh, svx, svy;

    always #5 pclk = ~pclk;

    rect_pos_ctrl dut (
        .pclk(pclk), .rst_n(rst_n), .vblnk_in(vblnk_in), .mode(mode),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_vx(cmd_vx), .cmd_vy(cmd_vy),
        .hmin(hmin), .hmax(hmax), .vmin(vmin), .vmax(vmax),
        .frame_tick(frame_tick), .pending(pending)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int sv4(input logic [3:0] b);
        return b[3] ? int'(b) - 16 : int'(b);
    endfunction

    function automatic int m_size(input int s, input int lim);
        if (s == 0) return 1;
        if (s > lim) return lim;
        return s;
    endfunction

    function automatic int neg(input int v);
        return (v == -8) ? 7 : -v;
    endfunction

    function automatic logic [39:0] exp_bounds();
        int a, b, c, d;
        a = mx; b = mx + mw - 1; c = my; d = my + mh - 1;
        return {a[9:0], b[9:0], c[9:0], d[9:0]};
    endfunction

    task automatic m_reset();
        mx = 0; my = 0; mw = 32; mh = 32; mvx = 0; mvy = 0; m_staged = 1'b0;
    endtask

    task automatic m_axis(inout int p, inout int v, input int s, input int lim);
        int np;
        np = p + v;
        if (np < 0) begin p = 0; v = neg(v); end
        else if (np + s > lim) begin p = lim - s; v = neg(v); end
        else p = np;
    endtask

    task automatic m_frame();
        if (m_staged) begin
            mw = m_size(sw, HA);
            mh = m_size(sh, VA);
            mx = (sx + mw > HA) ? HA - mw : sx;
            my = (sy + mh > VA) ? VA - mh : sy;
            mvx = svx; mvy = svy;
            m_staged = 1'b0;
        end else if (mode) begin
            m_axis(mx, mvx, mw, HA);
            m_axis(my, mvy, mh, VA);
        end
    endtask

    task automatic stage_model(input logic [9:0] x, y, w, h, input logic [3:0] vx, vy);
        sx = int'(x); sy = int'(y); sw = int'(w); sh = int'(h);
        svx = sv4(vx); svy = sv4(vy); m_staged = 1'b1;
    endtask

    task automatic send_cmd(input logic [9:0] x, y, w, h, input logic [3:0] vx, vy);
        int t;
        @(negedge pclk);
        cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_vx = vx; cmd_vy = vy;
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 50) begin @(negedge pclk); t++; end
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%b expected 1", cmd_ready);
        end
        @(posedge pclk);
        @(negedge pclk);
        cmd_valid = 1'b0;
        stage_model(x, y, w, h, vx, vy);
    endtask

    task automatic frame_step(input string tag);
        logic [39:0] old_b, new_b;
        old_b = exp_bounds();
        @(negedge pclk) vblnk_in = 1'b1;
        @(posedge pclk);
        m_frame();
        new_b = exp_bounds();
        @(posedge pclk); #1;
        n_vec++;
        if ({hmin, hmax, vmin, vmax} !== old_b || frame_tick !== 1'b0) begin
            n_err++;
            $display("FAIL %s early_change: bounds=%h tick=%b expected %h tick=0",
                     tag, {hmin, hmax, vmin, vmax}, frame_tick, old_b);
        end
        @(posedge pclk); #1;
        n_vec++;
        if ({hmin, hmax, vmin, vmax} !== new_b) begin
            n_err++;
            $display("FAIL %s bounds: got %h expected %h", tag, {hmin, hmax, vmin, vmax}, new_b);
        end
        n_vec++;
        if (frame_tick !== 1'b1) begin
            n_err++;
            $display("FAIL %s tick_pulse: got %b expected 1", tag, frame_tick);
        end
        @(posedge pclk); #1;
        n_vec++;
        if (frame_tick !== 1'b0) begin
            n_err++;
            $display("FAIL %s tick_width: got %b expected 0", tag, frame_tick);
        end
        repeat (3) @(posedge pclk);
        #1;
        n_vec++;
        if (frame_tick !== 1'b0 || {hmin, hmax, vmin, vmax} !== new_b) begin
            n_err++;
            $display("FAIL %s retrigger: tick=%b bounds=%h expected tick=0 bounds=%h",
                     tag, frame_tick, {hmin, hmax, vmin, vmax}, new_b);
        end
        @(negedge pclk) vblnk_in = 1'b0;
        repeat (3) @(negedge pclk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge pclk);
        n_vec++;
        if ({hmin, hmax, vmin, vmax} !== {10'd0, 10'd31, 10'd0, 10'd31}) begin
            n_err++;
            $display("FAIL reset_bounds: got %h expected %h", {hmin, hmax, vmin, vmax},
                     {10'd0, 10'd31, 10'd0, 10'd31});
        end
        n_vec++;
        if ({cmd_ready, frame_tick, pending} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_flags: ready/tick/pending=%b expected 100",
                     {cmd_ready, frame_tick, pending});
        end
        rst_n = 1'b1;
        m_reset();
        repeat (2) @(negedge pclk);
    endtask

    task automatic test_manual();
        mode = 1'b0;
        send_cmd(10'd100, 10'd50, 10'd40, 10'd20, 4'd0, 4'd0);
        repeat (3) @(negedge pclk);
        n_vec++;
        if ({pending, cmd_ready} !== 2'b10 || {hmin, hmax, vmin, vmax} !== exp_bounds()) begin
            n_err++;
            $display("FAIL manual_staged: pending/ready=%b bounds=%h expected 10 %h",
                     {pending, cmd_ready}, {hmin, hmax, vmin, vmax}, exp_bounds());
        end
        frame_step("manual");
        n_vec++;
        if ({hmin, hmax, vmin, vmax} !== {10'd100, 10'd139, 10'd50, 10'd69}) begin
            n_err++;
            $display("FAIL manual_literal: got %h expected %h", {hmin, hmax, vmin, vmax},
                     {10'd100, 10'd139, 10'd50, 10'd69});
        end
    endtask

    task automatic test_clamp_simul();
        logic [39:0] held;
        held = exp_bounds();
        @(negedge pclk);
        vblnk_in = 1'b1;
        cmd_x = 10'd790; cmd_y = 10'd10; cmd_w = 10'd40; cmd_h = 10'd0;
        cmd_vx = 4'd0; cmd_vy = 4'd0; cmd_valid = 1'b1;
        @(posedge pclk);
        @(negedge pclk) cmd_valid = 1'b0;
        stage_model(10'd790, 10'd10, 10'd40, 10'd0, 4'd0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (frame_tick !== 1'b0 || pending !== 1'b1 || {hmin, hmax, vmin, vmax} !== held) begin
                n_err++;
                $display("FAIL simul_no_update: tick=%b pending=%b bounds=%h expected 0 1 %h",
                         frame_tick, pending, {hmin, hmax, vmin, vmax}, held);
            end
            @(negedge pclk);
        end
        vblnk_in = 1'b0;
        repeat (3) @(negedge pclk);
        frame_step("clamp");
        n_vec++;
        if ({hmin, hmax, vmin, vmax} !== {10'd760, 10'd799, 10'd10, 10'd10}) begin
            n_err++;
            $display("FAIL clamp_literal: got %h expected %h", {hmin, hmax, vmin, vmax},
                     {10'd760, 10'd799, 10'd10, 10'd10});
        end
    endtask

    task automatic test_bounce();
        logic [9:0] exp_x [7];
        exp_x = '{10'd758, 10'd760, 10'd757, 10'd2, 10'd0, 10'd7, 10'd14};
        mode = 1'b1;
        send_cmd(10'd758, 10'd100, 10'd40, 10'd32, 4'd3, 4'd0);
        for (int i = 0; i < 7; i++) begin
            if (i == 3) send_cmd(10'd2, 10'd100, 10'd40, 10'd32, 4'b1000, 4'd0);
            frame_step("bounce");
            n_vec++;
            if (hmin !== exp_x[i]) begin
                n_err++;
                $display("FAIL bounce_step%0d: hmin=%0d expected %0d", i, hmin, exp_x[i]);
            end
        end
        mode = 1'b0;
    endtask

    task automatic test_back_to_back();
        mode = 1'b0;
        @(negedge pclk);
        cmd_x = 10'd200; cmd_y = 10'd150; cmd_w = 10'd64; cmd_h = 10'd48;
        cmd_vx = 4'd0; cmd_vy = 4'd0; cmd_valid = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        stage_model(10'd200, 10'd150, 10'd64, 10'd48, 4'd0, 4'd0);
        cmd_x = 10'd400; cmd_y = 10'd300; cmd_w = 10'd16; cmd_h = 10'd8;
        repeat (4) @(negedge pclk);
        n_vec++;
        if ({pending, cmd_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_hold: pending/ready=%b expected 10", {pending, cmd_ready});
        end
        frame_step("b2b_first");
        stage_model(10'd400, 10'd300, 10'd16, 10'd8, 4'd0, 4'd0);
        @(negedge pclk) cmd_valid = 1'b0;
        n_vec++;
        if (pending !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_second_accept: pending=%b expected 1", pending);
        end
        frame_step("b2b_second");
    endtask

    task automatic test_reset_pending();
        mode = 1'b0;
        send_cmd(10'd300, 10'd300, 10'd50, 10'd50, 4'd1, 4'd1);
        @(negedge pclk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({hmin, hmax, vmin, vmax} !== {10'd0, 10'd31, 10'd0, 10'd31}
            || {pending, cmd_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL rst_mid_pending: bounds=%h pending/ready=%b expected %h 01",
                     {hmin, hmax, vmin, vmax}, {pending, cmd_ready},
                     {10'd0, 10'd31, 10'd0, 10'd31});
        end
        @(negedge pclk) rst_n = 1'b1;
        m_reset();
        repeat (2) @(negedge pclk);
        frame_step("post_rst");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0)
                send_cmd(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                         10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                         4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            frame_step("random");
        end
        mode = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; vblnk_in = 1'b0; mode = 1'b0; cmd_valid = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_vx = '0; cmd_vy = '0;
        m_reset();
        test_reset();
        test_manual();
        test_clamp_simul();
        test_bounce();
        test_back_to_back();
        test_reset_pending();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rect_pos_ctrl.md
# rect_pos_ctrl

Frame-synchronous rectangle position controller that drives the `SAXI_HcountMin/Max` and `SAXI_VcountMin/Max` bounds of the RGB rectangle drawing stage. It accepts position, size and velocity commands through a valid/ready handshake and holds each command until the next vertical-blank start, so the drawing stage never sees a bound change mid-frame. It also supports an autonomous bounce mode that steps the rectangle by a signed velocity once per frame and reflects it off the active-area edges.

## Interface
- `H_ACTIVE`, 800: active pixels per line.
- `V_ACTIVE`, 600: active lines per frame.
- `INIT_X` / `INIT_Y`, 0 / 0: reset position.
- `INIT_W` / `INIT_H`, 32 / 32: reset size.

Ports (clock and reset first):
- `pclk` in 1: pixel clock; the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `vblnk_in` in 1: vertical blank from the VGA timing chain.
- `mode` in 1: 0 = manual, 1 = bounce; sampled only in UPDATE.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_x`, `cmd_y` in 10: requested top-left corner.
- `cmd_w`, `cmd_h` in 10: requested size.
- `cmd_vx`, `cmd_vy` in 4: signed velocity in pixels/frame, two's complement.
- `hmin`, `hmax`, `vmin`, `vmax` out 10: inclusive rectangle bounds for the drawing stage.
- `frame_tick` out 1: one-cycle pulse when new bounds are loaded.
- `pending` out 1: a staged command is waiting for vblank.

## Operation
- Edge detect:
  - `vblnk_d` is `vblnk_in` registered.
  - `vb_rise = vblnk_in & ~vblnk_d`.
- IDLE:
  - `cmd_ready = 1`.
  - When `cmd_valid` is high, capture all `cmd_*` fields into the staging registers and go to PENDING.
  - When `vb_rise` is high (and no command), go to UPDATE.
  - If `cmd_valid` and `vb_rise` occur together: the command is accepted, the FSM goes to PENDING, and this edge is not used. The command applies at the next `vb_rise`.
- PENDING:
  - `cmd_ready = 0` and `pending = 1`.
  - On `vb_rise`, go to UPDATE with `use_cmd = 1`.
- UPDATE (exactly 1 cycle): compute the next x, y, w, h, vx, vy, then go to LOAD.
  - If `use_cmd` is set, the staged command wins and no bounce step is taken that frame. Velocity registers load from the command.
  - Otherwise, if `mode = 1`, apply the bounce step.
  - Otherwise, hold the current position.
- LOAD (exactly 1 cycle): register the outputs, pulse `frame_tick`, clear `use_cmd`, return to IDLE.
- Size rule:
  - `w = 0` is treated as 1.
  - `w > H_ACTIVE` is clamped to `H_ACTIVE`.
  - `h` follows the same rule against `V_ACTIVE`.
- Position clamp: if `x + w > H_ACTIVE`, then `x = H_ACTIVE - w`. Same rule for y with `h` and `V_ACTIVE`.
- Bounce step (per axis):
  - Compute `nx = x + sext(vx)` in 12-bit signed.
  - If `nx < 0`: `x = 0`, `vx = -vx`.
  - Else if `nx + w > H_ACTIVE`: `x = H_ACTIVE - w`, `vx = -vx`.
  - Else: `x = nx`.
  - `vx = -8` negates to `+8`, which does not fit in 4 bits, so it saturates to `+7`.
  - Same rule for y.
- Outputs: `hmin = x`, `hmax = x + w - 1`, `vmin = y`, `vmax = y + h - 1`.
- Arithmetic width: all sums use 11-bit unsigned or 12-bit signed intermediates. No wrap-around is permitted.

## Timing
- Reset (asynchronous) values:
  - FSM in IDLE; `cmd_ready = 1`, `pending = 0`, `frame_tick = 0`, `vblnk_d = 0`.
  - `hmin = INIT_X`, `hmax = INIT_X + INIT_W - 1`, `vmin = INIT_Y`, `vmax = INIT_Y + INIT_H - 1`.
  - Velocity = 0.
- Latency: if `vblnk_in` is first sampled high at edge N, then UPDATE occupies cycle N+1 and the outputs and `frame_tick` change at edge N+2.
- Outputs change only at LOAD: at most once per frame, always inside vertical blank.
- Handshake:
  - A transfer occurs on an edge where `cmd_valid & cmd_ready`.
  - The upstream holds its data while `cmd_ready = 0`.
  - Only one command is buffered. A second command waits until the FSM returns to IDLE.
- LOAD always returns to IDLE even if `vblnk_in` remains high. No re-trigger occurs until `vblnk_in` falls and rises again.
- Reset asserted mid-PENDING: the staged command is discarded and outputs return to their INIT values immediately.

## Test plan
- Reset: hold `rst_n = 0` -> `hmin = 0`, `hmax = 31`, `vmin = 0`, `vmax = 31`, `cmd_ready = 1`, `frame_tick = 0`.
- Manual command: send `x = 100`, `y = 50`, `w = 40`, `h = 20` mid-frame -> `pending = 1`, `cmd_ready = 0`, outputs unchanged. Two edges after the vblank rise -> `hmin = 100`, `hmax = 139`, `vmin = 50`, `vmax = 69`, `frame_tick` pulses once.
- Clamp and simultaneity: send `x = 790`, `w = 40`, `h = 0` in the same cycle as the `vblnk_in` rise -> no update that frame. Next frame -> `hmin = 760`, `hmax = 799`, `vmax = vmin`.
- Bounce: `mode = 1`, `x = 758`, `w = 40`, `vx = +3` -> next frame `hmin = 760` and `vx` becomes -3. Following frame `hmin = 757`. Separately, `vx = -8` at `x = 2` -> `hmin = 0`, then `+7` steps.
- Backpressure: hold `cmd_valid` across two commands -> the second is accepted only after LOAD, and each command applies on its own frame.
- Reset mid-PENDING: pulse `rst_n` low while `pending = 1` -> outputs revert to INIT immediately, and the following vblank produces no command load.
